or_tree_pipe: RTL

Parametrised, pipelined wide-OR reduction cell for the 9-track 3.3 V standard-cell library. It is the multi-input, clocked successor of the two-input OR cell. It reduces a WIDTH-bit masked input vector to a single bit through a radix-2 OR tree, with a register stage inserted every LVLS tree levels. It offers an optional sticky (accumulating) output mode, and targets wide flag aggregation (interrupt/error OR-trees) where a flat combinational OR would not meet timing.

---
 rtl/or_tree_pipe.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/or_tree_pipe.sv
// ---------------------------------------------------------------------------
// or_tree_pipe
//
// Pipelined wide-OR reduction cell. The masked input vector (i & msk) is
// zero-padded to the next power of two and reduced to one bit by a radix-2
// OR tree. A register bank follows every LVLS tree levels, and the last
// bank is always the q register. An optional per-sample sticky mode
// accumulates results into q.
//
// Parameters
//   WIDTH   number of input bits (2..64)
//   LVLS    OR2 tree levels per register stage (1..6)
//
// Ports
//   ck      clock, rising edge
//   rst     asynchronous active-high reset
//   iv      input valid; i, msk and sticky are sampled when iv=1
//   i       data bits to be ORed
//   msk     per-bit enable (1 = bit participates)
//   sticky  accumulate mode for this sample, travels with the data
//   clr     synchronous clear of the output state, applied without delay
//   qv      one-cycle pulse when a sample's result reaches q
//   q       registered OR result (or accumulated OR in sticky mode)
//   nq      combinational ~q
// ---------------------------------------------------------------------------
module or_tree_pipe #(
  parameter int WIDTH = 16,
  parameter int LVLS  = 2
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             iv,
  input  logic [WIDTH-1:0] i,
  input  logic [WIDTH-1:0] msk,
  input  logic             sticky,
  input  logic             clr,
  output logic             qv,
  output logic             q,
  output logic             nq
);

  // Tree depth, number of register banks, and padded tree width.
  localparam int D  = $clog2(WIDTH);
  localparam int L  = (D + LVLS - 1) / LVLS;
  localparam int PW = 1 << D;

  // Number of OR2 levels evaluated in front of register bank s. Every bank
  // gets LVLS levels except possibly the last, which takes the remainder.
  function automatic int stage_lvls(input int s);
    int rem;
    rem = D - s * LVLS;
    return (rem < LVLS) ? rem : LVLS;
  endfunction

  // Applies nlev OR2 levels to a PW-wide vector. Results are packed into the
  // low bits in place (pair 2k,2k+1 lands at k); bits above the surviving
  // width are cleared so later stages only ever see zeros there.
  function automatic logic [PW-1:0] or_levels(input logic [PW-1:0] v,
                                               input int             nlev);
    logic [PW-1:0] t;
    t = v;
    for (int l = 0; l < D; l++) begin
      if (l < nlev) begin
        for (int k = 0; k < PW / 2; k++) begin
          t[k] = t[2*k] | t[2*k+1];
        end
      end
    end
    for (int k = 0; k < PW; k++) begin
      if (k >= (PW >> nlev)) t[k] = 1'b0;
    end
    return t;
  endfunction

  // Applies the final nlev levels and returns the root of the tree.
  function automatic logic or_root(input logic [PW-1:0] v,
                                   input int             nlev);
    logic [PW-1:0] t;
    t = v;
    for (int l = 0; l < D; l++) begin
      if (l < nlev) begin
        for (int k = 0; k < PW / 2; k++) begin
          t[k] = t[2*k] | t[2*k+1];
        end
      end
    end
    return t[0];
  endfunction

  localparam int LAST_LVLS = stage_lvls(L - 1);

  logic [PW-1:0] tree_in;
  logic [PW-1:0] last_in;
  logic          last_vld;
  logic          last_stk;
  logic          r;

  // Masked input, zero-padded to the full tree width. Padding bits are
  // constant zero, so they can never set q.
  assign tree_in = PW'(i & msk);

  if (L == 1) begin : g_single
    // Whole tree fits in front of the q register.
    assign last_in  = tree_in;
    assign last_vld = iv;
    assign last_stk = sticky;
  end else begin : g_pipe
    logic [PW-1:0] red    [L-1];
    logic [PW-1:0] data_p [L-1];
    logic          vld_p  [L-1];
    logic          stk_p  [L-1];

    for (genvar s = 0; s < L - 1; s++) begin : g_red
      localparam int NL = stage_lvls(s);
      if (s == 0) begin : g_first
        assign red[s] = or_levels(tree_in, NL);
      end else begin : g_next
        assign red[s] = or_levels(data_p[s-1], NL);
      end
    end

    // ---- intermediate register banks: p0 .. p(L-2) ----
    always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < L - 1; s++) begin
          data_p[s] <= '0;
          vld_p[s]  <= 1'b0;
          stk_p[s]  <= 1'b0;
        end
      end else begin
        data_p[0] <= red[0];
        vld_p[0]  <= iv;
        stk_p[0]  <= sticky;
        for (int s = 1; s < L - 1; s++) begin
          data_p[s] <= red[s];
          vld_p[s]  <= vld_p[s-1];
          stk_p[s]  <= stk_p[s-1];
        end
      end
    end

    assign last_in  = data_p[L-2];
    assign last_vld = vld_p[L-2];
    assign last_stk = stk_p[L-2];
  end

  // Remaining levels in front of the q register.
  assign r = or_root(last_in, LAST_LVLS);

  // ---- final register bank: q / qv ----
  // clr wins over accumulation but still loads an arriving result; with no
  // arrival it simply zeroes q.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      q  <= 1'b0;
      qv <= 1'b0;
    end else begin
      qv <= last_vld;
      if (last_vld) begin
        q <= (clr || !last_stk) ? r : (q | r);
      end else if (clr) begin
        q <= 1'b0;
      end
    end
  end

  assign nq = ~q;

endmodule
